// File: rtl/pos_emb_pkg.sv
// Shared types for the positional-embedding read address generator:
// request kinds, FSM states and the default pixel-beat size.
package pos_emb_pkg;

  localparam int PIX_BYTES_DEF = 32;

  typedef enum logic [1:0] {
    KIND_DAT_LO = 2'd0,
    KIND_DAT_HI = 2'd1,
    KIND_POS    = 2'd2
  } req_kind_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DAT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_POS    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/pos_emb_credit_cnt.sv
// Outstanding-request counter: counts issued-but-unreturned requests and
// flags when no credit is left or when every credit has come back.
module pos_emb_credit_cnt #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_dec_ok;

  // A return with nothing outstanding is stale (e.g. from before a reset).
  assign w_dec_ok = i_dec && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_dec_ok) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!i_inc && w_dec_ok) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_full  = (r_cnt == CNT_W'(MAX_OUTSTANDING));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/pos_emb_rd_agen.sv
// Read address generator for rotary positional embedding: walks head/group/token
// and issues DAT_LO, DAT_HI, POS reads. Optional POS_EMB_TOKEN_OFFSET_EN adds a token offset.
module pos_emb_rd_agen
  import pos_emb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int PIX_BYTES       = PIX_BYTES_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
`ifdef POS_EMB_TOKEN_OFFSET_EN
  input  logic [15:0]       tok_offset,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dat_base_addr,
  input  logic [ADDR_W-1:0] dat_head_stride,
  input  logic [ADDR_W-1:0] dat_line_stride,
  input  logic [ADDR_W-1:0] pos_base_addr,
  input  logic [ADDR_W-1:0] pos_line_stride,
  input  logic [7:0]        head_num,
  input  logic [15:0]       token_num,
  input  logic [7:0]        ch_div_tout,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [1:0]        req_kind,
  input  logic              rsp_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  // The high half-channel offset is needed once per run; a shift-add over the
  // 7-bit group count avoids a general multiplier.
  function automatic logic [ADDR_W-1:0] half_offset(input logic [6:0] n,
                                                    input logic [ADDR_W-1:0] s);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (n[i]) acc = acc + (s << i);
    end
    return acc;
  endfunction

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_head_base, r_line_base, r_lo_addr, r_hi_off;
  logic [ADDR_W-1:0] r_pos_base, r_pos_line, r_pos_addr, r_tokoff_b;
  logic [ADDR_W-1:0] r_head_stride, r_line_stride, r_pos_ls;
  logic [7:0]        r_head_num, r_h;
  logic [6:0]        r_half, r_g;
  logic [15:0]       r_tok_num, r_t;
  logic              r_cfg_err;
  logic [15:0]       w_tok_off;
  logic              w_full, w_empty, w_issue, w_xfer, w_accept, w_cfg_bad;
  logic              w_last_t, w_last_g, w_last_h;
  logic [ADDR_W-1:0] w_next_head, w_next_line, w_next_pline;

`ifdef POS_EMB_TOKEN_OFFSET_EN
  assign w_tok_off = tok_offset;
`else
  assign w_tok_off = '0;
`endif

  assign w_cfg_bad = (head_num == 8'd0) || (token_num == 16'd0) ||
                     (ch_div_tout == 8'd0) || ch_div_tout[0];
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_issue   = (r_state == S_DAT_LO) || (r_state == S_DAT_HI) || (r_state == S_POS);
  assign req_valid = w_issue && !w_full;
  assign w_xfer    = req_valid && req_ready;
  assign w_last_t  = (r_t == r_tok_num - 16'd1);
  assign w_last_g  = (r_g == r_half - 7'd1);
  assign w_last_h  = (r_h == r_head_num - 8'd1);
  assign w_next_head  = r_head_base + r_head_stride;
  assign w_next_line  = r_line_base + r_line_stride;
  assign w_next_pline = r_pos_line + r_pos_ls;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign cfg_err = r_cfg_err;

  always_comb begin
    req_addr = '0;
    req_kind = KIND_DAT_LO;
    case (r_state)
      S_DAT_LO: req_addr = r_lo_addr;
      S_DAT_HI: begin req_addr = r_lo_addr + r_hi_off; req_kind = KIND_DAT_HI; end
      S_POS:    begin req_addr = r_pos_addr;           req_kind = KIND_POS;    end
      default:  ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = w_cfg_bad ? S_DONE : S_DAT_LO;
      S_DAT_LO: if (w_xfer) w_state_nxt = S_DAT_HI;
      S_DAT_HI: if (w_xfer) w_state_nxt = S_POS;
      S_POS:    if (w_xfer) w_state_nxt = (w_last_t && w_last_g && w_last_h) ? S_DRAIN : S_DAT_LO;
      S_DRAIN:  if (w_empty) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_cfg_err <= w_cfg_bad;
    end
  end

  // Walk state: every address is the previous one plus a captured stride.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_base <= '0; r_line_base <= '0; r_lo_addr <= '0; r_hi_off <= '0;
      r_pos_base <= '0; r_pos_line <= '0; r_pos_addr <= '0; r_tokoff_b <= '0;
      r_head_stride <= '0; r_line_stride <= '0; r_pos_ls <= '0;
      r_head_num <= '0; r_half <= '0; r_tok_num <= '0;
      r_h <= '0; r_g <= '0; r_t <= '0;
    end else if (w_accept && !w_cfg_bad) begin
      r_head_base   <= dat_base_addr;
      r_line_base   <= dat_base_addr;
      r_lo_addr     <= dat_base_addr;
      r_hi_off      <= half_offset(ch_div_tout[7:1], dat_line_stride);
      r_pos_base    <= pos_base_addr;
      r_pos_line    <= pos_base_addr;
      r_pos_addr    <= pos_base_addr + ADDR_W'(w_tok_off) * ADDR_W'(PIX_BYTES);
      r_tokoff_b    <= ADDR_W'(w_tok_off) * ADDR_W'(PIX_BYTES);
      r_head_stride <= dat_head_stride;
      r_line_stride <= dat_line_stride;
      r_pos_ls      <= pos_line_stride;
      r_head_num    <= head_num;
      r_half        <= ch_div_tout[7:1];
      r_tok_num     <= token_num;
      r_h <= '0; r_g <= '0; r_t <= '0;
    end else if (w_xfer && (r_state == S_POS)) begin
      if (!w_last_t) begin
        r_t        <= r_t + 16'd1;
        r_lo_addr  <= r_lo_addr + ADDR_W'(PIX_BYTES);
        r_pos_addr <= r_pos_addr + ADDR_W'(PIX_BYTES);
      end else if (!w_last_g) begin
        r_t         <= '0;
        r_g         <= r_g + 7'd1;
        r_line_base <= w_next_line;
        r_lo_addr   <= w_next_line;
        r_pos_line  <= w_next_pline;
        r_pos_addr  <= w_next_pline + r_tokoff_b;
      end else if (!w_last_h) begin
        r_t         <= '0;
        r_g         <= '0;
        r_h         <= r_h + 8'd1;
        r_head_base <= w_next_head;
        r_line_base <= w_next_head;
        r_lo_addr   <= w_next_head;
        r_pos_line  <= r_pos_base;
        r_pos_addr  <= r_pos_base + r_tokoff_b;
      end
    end
  end

  pos_emb_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_xfer),
    .i_dec  (rsp_done),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule

// File: tb/tb_pos_emb_rd_agen.sv
// Scoreboard bench for pos_emb_rd_agen: directed runs push expected requests,
// a negedge monitor pops and compares every transfer.
module tb_pos_emb_rd_agen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dat_base_addr, dat_head_stride, dat_line_stride;
  logic [31:0] pos_base_addr, pos_line_stride;
  logic [7:0]  head_num, ch_div_tout;
  logic [15:0] token_num, tok_offset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_kind;
  logic        rsp_done = 1'b0;
  logic        busy, done, cfg_err;
  logic        auto_rsp = 1'b1;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  k;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;
  int tb_out   = 0;
  logic        p_stall = 1'b0;
  logic [31:0] p_addr  = '0;
  logic [1:0]  p_kind  = '0;

  pos_emb_rd_agen dut (
`ifdef POS_EMB_TOKEN_OFFSET_EN
    .tok_offset     (tok_offset),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dat_base_addr  (dat_base_addr),
    .dat_head_stride(dat_head_stride),
    .dat_line_stride(dat_line_stride),
    .pos_base_addr  (pos_base_addr),
    .pos_line_stride(pos_line_stride),
    .head_num       (head_num),
    .token_num      (token_num),
    .ch_div_tout    (ch_div_tout),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_kind       (req_kind),
    .rsp_done       (rsp_done),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
  endtask

  // Monitor: sampled mid-cycle, so a valid&&ready seen here transfers at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      tb_out  = 0;
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_valid", 64'(req_valid), 64'd1);
        check("hold_addr", 64'(req_addr), 64'(p_addr));
        check("hold_kind", 64'(req_kind), 64'(p_kind));
      end
      if (req_valid && req_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_req", 64'(req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("req_addr", 64'(req_addr), 64'(e.a));
          check("req_kind", 64'(req_kind), 64'(e.k));
        end
        xfer_cnt++;
        tb_out++;
      end
      if (rsp_done && tb_out > 0) tb_out--;
      p_stall = req_valid && !req_ready;
      p_addr  = req_addr;
      p_kind  = req_kind;
    end
  end

  // Responder: returns one outstanding request per cycle when enabled.
  always @(posedge clk) begin
    #1;
    rsp_done = auto_rsp && rst_n && (tb_out > 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input logic [31:0] db, hs, ls, pb, pls,
                         input logic [7:0] hn, input logic [15:0] tn, input logic [7:0] cd);
    dat_base_addr = db; dat_head_stride = hs; dat_line_stride = ls;
    pos_base_addr = pb; pos_line_stride = pls;
    head_num = hn; token_num = tn; ch_div_tout = cd;
  endtask

  task automatic pulse_start(input bit expect_req);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (expect_req) begin
      check("first_valid_latency", 64'(req_valid), 64'd1);
      check("busy_running", 64'(busy), 64'd1);
    end
  endtask

  task automatic push_ref12();
    logic [31:0] tab [12];
    tab = '{32'h0, 32'h400, 32'h400_0000, 32'h20, 32'h420, 32'h400_0020,
            32'h200, 32'h600, 32'h400_0200, 32'h220, 32'h620, 32'h400_0220};
    for (int i = 0; i < 12; i++) sb.push_back('{a: tab[i], k: 2'(i % 3)});
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) begin cyc = i; break; end
    end
    check("done_seen", 64'(cyc >= 0), 64'd1);
    @(negedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc, base, tmo;
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b1; tok_offset = '0;
    set_cfg(32'h0, 32'h1000, 32'h200, 32'h400_0000, 32'h200, 8'd1, 16'd2, 8'd4);
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reference walk: 1 head, 2 tokens, 2 channel-group pairs.
    base = xfer_cnt;
    push_ref12();
    pulse_start(1'b1);
    wait_done(200, cyc);
    check("ref_xfers", 64'(xfer_cnt - base), 64'd12);
    check("ref_sb_empty", 64'(sb.size()), 64'd0);
    check("ref_cfg_err", 64'(cfg_err), 64'd0);

    // Two heads, nonzero bases: POS table rewinds on every head.
    set_cfg(32'h100, 32'h1000, 32'h200, 32'h8000, 32'h40, 8'd2, 16'd1, 8'd2);
    sb.push_back('{a: 32'h100,  k: 2'd0}); sb.push_back('{a: 32'h300,  k: 2'd1});
    sb.push_back('{a: 32'h8000, k: 2'd2}); sb.push_back('{a: 32'h1100, k: 2'd0});
    sb.push_back('{a: 32'h1300, k: 2'd1}); sb.push_back('{a: 32'h8000, k: 2'd2});
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_done(200, cyc);
    check("heads_xfers", 64'(xfer_cnt - base), 64'd6);

    // Backpressure on the second request.
    set_cfg(32'h0, 32'h1000, 32'h200, 32'h400_0000, 32'h200, 8'd1, 16'd2, 8'd4);
    push_ref12();
    base = xfer_cnt;
    pulse_start(1'b1);
    tmo = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt - base >= 1) begin tmo = 0; break; end
    end
    check("bp_first_xfer", 64'(tmo), 64'd0);
    @(posedge clk); #1 req_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_addr", 64'(req_addr), 64'h400);
      check("bp_kind", 64'(req_kind), 64'd1);
      @(posedge clk); #1;
    end
    req_ready = 1'b1;
    wait_done(200, cyc);
    check("bp_xfers", 64'(xfer_cnt - base), 64'd12);

    // Credit limit: responses withheld.
    auto_rsp = 1'b0;
    push_ref12();
    base = xfer_cnt;
    pulse_start(1'b1);
    repeat (20) @(negedge clk);
    #1;
    check("credit_xfers", 64'(xfer_cnt - base), 64'd8);
    check("credit_valid_low", 64'(req_valid), 64'd0);
    auto_rsp = 1'b1;
    wait_done(200, cyc);
    check("credit_resume_xfers", 64'(xfer_cnt - base), 64'd12);

    // Odd channel-group count.
    set_cfg(32'h0, 32'h1000, 32'h200, 32'h400_0000, 32'h200, 8'd1, 16'd2, 8'd3);
    base = xfer_cnt;
    pulse_start(1'b0);
    wait_done(5, cyc);
    check("cfgerr_done_latency", 64'(cyc <= 1), 64'd1);
    check("cfgerr_flag", 64'(cfg_err), 64'd1);
    repeat (3) @(negedge clk);
    check("cfgerr_sticky", 64'(cfg_err), 64'd1);
    check("cfgerr_no_xfers", 64'(xfer_cnt - base), 64'd0);

    // Reset in the middle of a burst, then a clean restart.
    set_cfg(32'h0, 32'h1000, 32'h200, 32'h400_0000, 32'h200, 8'd1, 16'd2, 8'd4);
    push_ref12();
    base = xfer_cnt;
    pulse_start(1'b1);
    check("cfgerr_cleared", 64'(cfg_err), 64'd0);
    tmo = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt - base >= 5) begin tmo = 0; break; end
    end
    check("rst_mid_reach5", 64'(tmo), 64'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(req_valid), 64'd0);
    check("midrst_addr", 64'(req_addr), 64'd0);
    check("midrst_kind", 64'(req_kind), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    push_ref12();
    base = xfer_cnt;
    pulse_start(1'b1);
    check("restart_addr0", 64'(req_addr), 64'h0);
    wait_done(200, cyc);
    check("restart_xfers", 64'(xfer_cnt - base), 64'd12);

`ifdef POS_EMB_TOKEN_OFFSET_EN
    // KV-cache offset shifts only the POS address.
    set_cfg(32'h0, 32'h1000, 32'h200, 32'h400_0000, 32'h200, 8'd1, 16'd1, 8'd2);
    tok_offset = 16'd48;
    sb.push_back('{a: 32'h0, k: 2'd0}); sb.push_back('{a: 32'h200, k: 2'd1});
    sb.push_back('{a: 32'h400_0600, k: 2'd2});
    base = xfer_cnt;
    pulse_start(1'b1);
    wait_done(200, cyc);
    check("tokoff_xfers", 64'(xfer_cnt - base), 64'd3);
`endif

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
